// File: rtl/mem_arb_pkg.sv
// Shared state encoding, request-size encoding and size-to-byte-count helper
// for the byte-serial memory arbiter/controller.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_STORE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_1B   = 2'd0;
  localparam logic [1:0] SIZE_2B   = 2'd1;
  localparam logic [1:0] SIZE_4B   = 2'd2;
  localparam logic [1:0] SIZE_RSVD = 2'd3;

  // Reserved size maps to the full data width; never exceed max_bytes.
  function automatic int unsigned size_to_bytes(input logic [1:0] size,
                                                input int unsigned max_bytes);
    int unsigned n;
    case (size)
      SIZE_1B: n = 1;
      SIZE_2B: n = 2;
      SIZE_4B: n = 4;
      default: n = max_bytes;
    endcase
    if (n > max_bytes) n = max_bytes;
    return n;
  endfunction

endpackage

// File: rtl/mem_rr_arbiter.sv
// Combinational grant from req starting at a search pointer; the pointer
// advances past each taken grant when RR_EN is set and stays 0 otherwise.
module mem_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter bit RR_EN     = 1'b0,
  localparam int IDX_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 take,
  output logic                 gnt_vld,
  output logic [IDX_W-1:0]     gnt_idx
);

  logic [IDX_W-1:0] ptr;
  int               cand;

  // Walk downward so the candidate closest to ptr is written last and wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      cand = (int'(ptr) + i) % NUM_PORTS;
      if (req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDX_W'(cand);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ptr <= '0;
    end else if (rdy_in && take && gnt_vld && RR_EN) begin
      ptr <= IDX_W'((int'(gnt_idx) + 1) % NUM_PORTS);
    end
  end

endmodule

// File: rtl/mem_arbiter_ctrl.sv
// N-port byte-serial RAM controller: n-byte request completes n+2 cycles after accept; rdy_in low freezes all state.
// Arbitration is fixed priority (port 0 first) unless MEM_ARB_RR_EN is defined, which selects round-robin.
module mem_arbiter_ctrl
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_BYTES = 4
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             rdy_in,
  input  logic [7:0]                       mem_din,
  output logic [7:0]                       mem_dout,
  output logic [ADDR_W-1:0]                mem_a,
  output logic                             mem_wr,
  input  logic [NUM_PORTS-1:0]             req,
  input  logic [NUM_PORTS-1:0]             req_we,
  input  logic [2*NUM_PORTS-1:0]           req_size,
  input  logic [NUM_PORTS-1:0]             req_sext,
  input  logic [ADDR_W*NUM_PORTS-1:0]      req_addr,
  input  logic [8*DATA_BYTES*NUM_PORTS-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]             resp_valid,
  output logic [8*DATA_BYTES-1:0]          resp_data
);

  localparam int DATA_W = 8 * DATA_BYTES;
  localparam int IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W  = $clog2(DATA_BYTES) + 1;
`ifdef MEM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 sext_q, sext_d;
  logic [CNT_W-1:0]     n_q, n_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [DATA_W-1:0]    acc_q, acc_d;
  logic [ADDR_W-1:0]    mem_a_d;
  logic [7:0]           mem_dout_d;
  logic                 mem_wr_d;
  logic [NUM_PORTS-1:0] resp_valid_d;
  logic [DATA_W-1:0]    resp_data_d;
  logic [DATA_W-1:0]    load_word, ext_word;
  logic                 sign_bit;
  logic                 gnt_vld;
  logic [IDX_W-1:0]     gnt_idx;

  mem_rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .RR_EN     (RR_EN)
  ) u_arb (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .rdy_in  (rdy_in),
    .req     (req),
    .take    (state_q == ST_IDLE),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    sext_d       = sext_q;
    n_d          = n_q;
    cnt_d        = cnt_q;
    wdata_d      = wdata_q;
    acc_d        = acc_q;
    mem_a_d      = mem_a;
    mem_dout_d   = mem_dout;
    mem_wr_d     = mem_wr;
    resp_valid_d = '0;
    resp_data_d  = resp_data;

    load_word = acc_q;
    load_word[8*cnt_q +: 8] = mem_din;
    // Bytes above the transfer size take the sign of the top transferred byte.
    sign_bit = sext_q & load_word[8*int'(n_q)-1];
    ext_word = load_word;
    for (int b = 0; b < DATA_BYTES; b++) begin
      if (b >= int'(n_q)) ext_word[8*b +: 8] = {8{sign_bit}};
    end

    case (state_q)
      ST_IDLE: begin
        mem_a_d    = '0;
        mem_dout_d = '0;
        mem_wr_d   = 1'b0;
        if (gnt_vld) begin
          idx_d   = gnt_idx;
          sext_d  = req_sext[gnt_idx];
          n_d     = CNT_W'(size_to_bytes(req_size[2*gnt_idx +: 2], DATA_BYTES));
          wdata_d = req_wdata[DATA_W*gnt_idx +: DATA_W];
          mem_a_d = req_addr[ADDR_W*gnt_idx +: ADDR_W];
          cnt_d   = '0;
          acc_d   = '0;
          if (req_we[gnt_idx]) begin
            // First store byte goes out with the address: no dead cycle.
            mem_dout_d = req_wdata[DATA_W*gnt_idx +: 8];
            mem_wr_d   = 1'b1;
            cnt_d      = CNT_W'(1);
            state_d    = ST_STORE;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        acc_d = load_word;
        if (cnt_q == n_q - CNT_W'(1)) begin
          resp_data_d         = ext_word;
          resp_valid_d[idx_q] = 1'b1;
          mem_a_d             = '0;
          state_d             = ST_DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          mem_a_d = mem_a + ADDR_W'(1);
        end
      end
      ST_STORE: begin
        if (cnt_q == n_q) begin
          mem_wr_d            = 1'b0;
          mem_dout_d          = '0;
          mem_a_d             = '0;
          resp_valid_d[idx_q] = 1'b1;
          state_d             = ST_DONE;
        end else begin
          mem_a_d    = mem_a + ADDR_W'(1);
          mem_dout_d = wdata_q[8*cnt_q +: 8];
          cnt_d      = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      sext_q     <= 1'b0;
      n_q        <= '0;
      cnt_q      <= '0;
      wdata_q    <= '0;
      acc_q      <= '0;
      mem_a      <= '0;
      mem_dout   <= '0;
      mem_wr     <= 1'b0;
      resp_valid <= '0;
      resp_data  <= '0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      sext_q     <= sext_d;
      n_q        <= n_d;
      cnt_q      <= cnt_d;
      wdata_q    <= wdata_d;
      acc_q      <= acc_d;
      mem_a      <= mem_a_d;
      mem_dout   <= mem_dout_d;
      mem_wr     <= mem_wr_d;
      resp_valid <= resp_valid_d;
      resp_data  <= resp_data_d;
    end
  end

endmodule

// File: doc/mem_arbiter_ctrl.md
# mem_arbiter_ctrl

Parametrised byte-serial memory controller that arbitrates NUM_PORTS requesters (instruction fetch, load/store unit, future DMA/prefetch) onto the single 8-bit RAM port. It generalises the two-client fetch/load/store controller to N ports, per-request size and sign-extension, and configurable arbitration. It sits between the clients and the top-level RAM bus. Stores drive the first byte in the acceptance cycle, so no dead address cycle is spent.

## Interface
Parameters:
- NUM_PORTS, 2, number of requesters; port 0 is highest priority under fixed arbitration
- ADDR_W, 32, request and mem_a address width
- DATA_BYTES, 4, maximum bytes per request; data width is 8*DATA_BYTES

Ports:
- clk_in  in  1  clock; all state changes on rising edge
- rst_in  in  1  reset, synchronous, active-high
- rdy_in  in  1  global enable; low freezes every register
- mem_din  in  8  RAM read data, valid one cycle after address
- mem_dout  out  8  RAM write data
- mem_a  out  ADDR_W  RAM byte address
- mem_wr  out  1  1 = write
- req  in  NUM_PORTS  per-port request, held until that port's resp_valid
- req_we  in  NUM_PORTS  per-port 1 = store, 0 = load
- req_size  in  2*NUM_PORTS  per-port log2 byte count (0:1B, 1:2B, 2:4B; 3 reserved)
- req_sext  in  NUM_PORTS  per-port sign-extend load result
- req_addr  in  ADDR_W*NUM_PORTS  per-port start address
- req_wdata  in  8*DATA_BYTES*NUM_PORTS  per-port store data, byte 0 written first
- resp_valid  out  NUM_PORTS  one-hot, one-cycle completion pulse
- resp_data  out  8*DATA_BYTES  load result, meaningful while resp_valid set

## Operation
- States: IDLE, LOAD, STORE, DONE.
- IDLE: if any req, grant one port g, latch its we/size/sext/addr/wdata, byte count n = 1<<size, byte index cnt = 0.
  - Load: mem_a <= addr, mem_wr <= 0, go LOAD.
  - Store: mem_a <= addr, mem_dout <= wdata[7:0], mem_wr <= 1, cnt <= 1, go STORE.
  - No req: mem_a, mem_dout, mem_wr <= 0.
- LOAD, each edge: capture mem_din into byte cnt of the result. If cnt == n-1: apply extension (sext: replicate bit 8n-1; otherwise zero-fill), set resp_valid[g], mem_a <= 0, go DONE. Otherwise cnt++, mem_a++.
- STORE, each edge: if cnt == n: mem_wr <= 0, mem_dout <= 0, mem_a <= 0, set resp_valid[g], go DONE. Otherwise mem_a++, mem_dout <= byte cnt, cnt++.
- DONE: clear resp_valid, go IDLE. Gives the requester one cycle to drop req.
- req_size 3 is treated as DATA_BYTES.
- Addresses increment modulo 2^ADDR_W; no alignment check.
- Non-granted requests wait, and their inputs must stay stable.
- resp_data holds its last value until the next load completes.

## Timing
- Reset values: mem_dout, mem_a, mem_wr = 0; resp_valid = 0; resp_data = 0; state IDLE; round-robin pointer = 0.
- Load of n bytes: resp_valid is high in the cycle after edge n counted from the acceptance edge (edge 0).
- Store of n bytes: mem_wr is high for exactly n cycles at consecutive addresses; resp_valid follows the same edge count as loads.
- Back-to-back throughput: n + 2 cycles per request (accept, n transfer, DONE).
- rdy_in low: state, counters and all outputs hold; mem_wr stays at its value.
- rst_in mid-transfer: transfer is abandoned, no resp_valid, mem_wr is 0 on the next cycle.
- Simultaneous requests: exactly one grant per IDLE cycle.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration. The search starts at the port after the last granted one, and the pointer updates on each grant.
- MEM_ARB_RR_EN undefined: fixed priority, lowest index wins. Starvation of high indices is allowed.

## Structure
- Package mem_arb_pkg: state enum, size encoding constants, helper function that maps size to byte count.
- One sub-module, mem_rr_arbiter: combinational grant from req and pointer, plus the registered pointer. It is instantiated in both modes; in fixed mode the pointer is tied to 0.

## Test plan
- Load 4B from 0x100 (RAM holds 0x11,0x22,0x33,0x44) on port 1 -> mem_a steps 0x100..0x103; resp_valid[1] pulses 4 edges after accept with resp_data 0x44332211.
- Load 1B sext from byte 0x80 -> resp_data 0xFFFFFF80; same with sext = 0 -> 0x00000080; 2B sext of 0x8001 -> 0xFFFF8001.
- Store 2B 0xBEEF to 0x200 -> mem_wr high for 2 cycles with (0x200, 0xEF) then (0x201, 0xBE); resp_valid pulses; mem_wr is 0 afterwards.
- Ports 0 and 1 both requesting continuously -> fixed mode serves only port 0; with MEM_ARB_RR_EN grants alternate 0,1,0,1.
- rdy_in low for 3 cycles mid-load -> outputs frozen, result still correct, latency extended by exactly 3 cycles.
- rst_in asserted mid-store -> no resp_valid, mem_wr is 0 the next cycle, IDLE accepts a fresh request afterwards.
